// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MIPS multiply/divide unit owning HI/LO.
// Define MULDIV_FAST_MULT_EN for single-cycle combinational MULT/MULTU.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  localparam int CW = $clog2(ITER);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] opb, a_raw, abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH:0] rem, rsh, diff, msum;
  logic neg_q, neg_r, is_div, sa, sb, accept, go_mul, go_div, ge, last;
  assign busy   = state != IDLE;
  assign accept = start && !busy;
  assign go_mul = accept && op[2:1] == 2'b00;
  assign go_div = accept && op[2:1] == 2'b01;
  assign sa     = !op[0] && src_a[WIDTH-1];
  assign sb     = !op[0] && src_b[WIDTH-1];
  assign abs_a  = sa ? -src_a : src_a;
  assign abs_b  = sb ? -src_b : src_b;
  assign last   = cnt == CW'(ITER - 1);
  // Multiply: acc holds {partial product, remaining multiplier bits}
  assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in
  assign rsh    = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign diff   = rsh - {1'b0, opb};
  assign ge     = !diff[WIDTH];
  assign prod   = neg_q ? -acc : acc;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fmag, fprod;
  assign fmag  = (2*WIDTH)'(abs_a) * (2*WIDTH)'(abs_b);
  assign fprod = (sa ^ sb) ? -fmag : fmag;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
`ifdef MULDIV_FAST_MULT_EN
      IDLE:     state_nx = go_div ? DIV : IDLE;
`else
      IDLE:     state_nx = go_div ? DIV : go_mul ? MUL : IDLE;
`endif
      MUL, DIV: state_nx = last ? FIX : state;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      opb    <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == MUL || state == DIV) ? cnt + CW'(1) : '0;
      if (go_mul || go_div) begin
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        a_raw  <= src_a;
        is_div <= go_div;
        opb    <= go_div ? abs_b : abs_a;
        acc    <= {{WIDTH{1'b0}}, go_div ? abs_a : abs_b};
        rem    <= '0;
      end
      if (state == MUL) acc <= {msum, acc[WIDTH-1:1]};
      if (state == DIV) begin
        rem             <= ge ? diff : rsh;
        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ge};
      end
      if (state == FIX) begin
        done     <= 1'b1;
        {hi, lo} <= !is_div ? prod :
                    opb == '0 ? {a_raw, {WIDTH{1'b1}}} :
                    {neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0],
                     neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]};
      end
      if (accept && op == 3'b100) hi <= src_a;
      if (accept && op == 3'b101) lo <= src_a;
`ifdef MULDIV_FAST_MULT_EN
      if (go_mul) begin
        {hi, lo} <= fprod;
        done     <= 1'b1;
      end
`endif
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit owning the architectural HI/LO pair; sits beside the ALU in the execute stage.
- Receives operands from the same source muxes as the ALU. Produces HI/LO for MFHI/MFLO readback.
- Asserts `busy` so the control unit stalls any HI/LO consumer or new mul/div until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles, one quotient/product bit per cycle; fixed equal to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only when busy=0.
- op  input  3  operation code:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- src_a  input  WIDTH  multiplicand / dividend / MTHI or MTLO data.
- src_b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an iterative operation is in flight.
- done  output  1  one-cycle pulse in the cycle HI/LO become valid.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, reset_n=0):
  - hi=0, lo=0, busy=0, done=0; FSM to IDLE.
  - Any in-flight operation is discarded; HI/LO are not partially updated.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, start=1:
  - op MTHI/MTLO: write hi or lo with src_a at that edge; no busy, no done.
  - op MULT/MULTU: latch operands, go to MUL.
  - op DIV/DIVU: latch operands, go to DIV.
  - op 110/111: ignored.
- Signed ops (MULT, DIV):
  - Latch absolute values of the operands.
  - Record negate-product/quotient flag = sign_a XOR sign_b.
  - Record negate-remainder flag = sign_a.
  - Unsigned ops clear both flags.
- MUL: shift-add. One multiplier bit per cycle, 64-bit accumulator, ITER cycles, then go to FIX.
- DIV: restoring divide. One quotient bit per cycle, WIDTH+1-bit partial remainder, ITER cycles, then go to FIX.
- FIX (one cycle): apply the sign flags, write hi/lo, pulse done=1, drop busy, return to IDLE.
- Timing, with start accepted at edge E0:
  - busy=1 from after E0 through E33.
  - hi/lo update and done=1 after E33.
  - Busy span is 33 cycles; the next start is accepted at E34.
- start while busy=1: ignored entirely, including MTHI/MTLO. The control unit must stall.
- hi/lo hold their previous values for the whole busy span. Reads during busy return old values; stalling them is the control unit's job.
- Result placement:
  - MULT/MULTU: {hi,lo} = full 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: still takes 33 cycles; lo = 32'hFFFFFFFF, hi = src_a as latched (raw, before abs).
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (two's-complement wrap, no trap).
- Operands are latched at E0; src_a/src_b changes during busy have no effect.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU complete in a single cycle using a combinational WIDTHxWIDTH multiplier.
  - hi/lo written and done pulsed at E0+1; busy never asserts for multiply.
  - DIV/DIVU timing is unchanged.
- Undefined: multiply uses the 33-cycle iterative path described above.

Test Plan:
- MULTU, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after 33 busy cycles: hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT, src_a=-7 (0xFFFFFFF9), src_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- DIV, src_a=-7, src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU, src_a=100, src_b=0 -> lo=0xFFFFFFFF, hi=100.
- DIV, src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Control cases:
  - MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, no busy.
  - start DIV, then a MTLO strobe mid-busy -> the MTLO is ignored.
  - reset_n=0 at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately, no done pulse.
